// File: rtl/wb_ic_pkg.sv
// Shared definitions for the shared-bus Wishbone interconnect:
// decode width, watchdog width helper and response-select helper.
package wb_ic_pkg;

   localparam int DECW = 4;

   function automatic int tmo_w(input int t);
      return $clog2(t + 1);
   endfunction

   function automatic logic pick(
      input logic [15:0]     v,
      input logic [DECW-1:0] i,
      input logic            en
   );
      return en & v[i];
   endfunction

endpackage

// File: rtl/wb_shared_ic_if.sv
// Flattened Wishbone bus bundle: master-side and slave-side signals.
// The interconnect takes the slave modport, the environment the master one.
interface wb_shared_ic_if #(
   parameter int NM = 2,
   parameter int NS = 4,
   parameter int DW = 32,
   parameter int AW = 32
);
   localparam int SW = DW / 8;

   logic [NM-1:0]    m_cyc_i;
   logic [NM-1:0]    m_stb_i;
   logic [NM-1:0]    m_we_i;
   logic [NM*AW-1:0] m_adr_i;
   logic [NM*SW-1:0] m_sel_i;
   logic [NM*DW-1:0] m_dat_i;
   logic [DW-1:0]    m_dat_o;
   logic [NM-1:0]    m_ack_o;
   logic [NM-1:0]    m_err_o;
   logic [NM-1:0]    m_rty_o;

   logic [NS-1:0]    s_cyc_o;
   logic [NS-1:0]    s_stb_o;
   logic             s_we_o;
   logic [AW-1:0]    s_adr_o;
   logic [SW-1:0]    s_sel_o;
   logic [DW-1:0]    s_dat_o;
   logic [NS*DW-1:0] s_dat_i;
   logic [NS-1:0]    s_ack_i;
   logic [NS-1:0]    s_err_i;
   logic [NS-1:0]    s_rty_i;

   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i,
      input  m_adr_i, m_sel_i, m_dat_i,
      input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
      output m_dat_o, m_ack_o, m_err_o, m_rty_o,
      output s_cyc_o, s_stb_o, s_we_o,
      output s_adr_o, s_sel_o, s_dat_o
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i,
      output m_adr_i, m_sel_i, m_dat_i,
      output s_dat_i, s_ack_i, s_err_i, s_rty_i,
      input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
      input  s_cyc_o, s_stb_o, s_we_o,
      input  s_adr_o, s_sel_o, s_dat_o
   );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant.
// The current holder keeps the grant while hold_i is set.
module wb_rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] req_i,
   input  logic         hold_i,
   output logic [N-1:0] gnt_o
);

   localparam int LW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]  gnt_q, gnt_d;
   logic [LW-1:0] last_q, last_d;
   int            j;

   // Search starts just after the last winner so it ends up lowest priority.
   always_comb begin
      gnt_d  = '0;
      last_d = last_q;
      j      = 0;
      if (hold_i) begin
         gnt_d = gnt_q;
      end else begin
         for (int k = 1; k <= N; k++) begin
            j = (int'(last_q) + k) % N;
            if (gnt_d == '0 && req_i[j]) begin
               gnt_d[j] = 1'b1;
               last_d   = LW'(j);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gnt_q  <= '0;
         last_q <= LW'(N - 1);
      end else begin
         gnt_q  <= gnt_d;
         last_q <= last_d;
      end
   end

   assign gnt_o = gnt_q;

endmodule

// File: rtl/wb_shared_ic.sv
// Shared-bus Wishbone interconnect: NM masters, NS slaves, one transfer
// at a time, with round-robin grant, unmapped-address error and watchdog.
module wb_shared_ic
   import wb_ic_pkg::*;
#(
   parameter int NM      = 2,
   parameter int NS      = 4,
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk_i,
   input  logic          rst_i,
   wb_shared_ic_if.slave bus,
   output logic [NM-1:0] grant_o,
   output logic          tmo_o
);

   localparam int SW = DW / 8;
   localparam int TW = tmo_w(TIMEOUT);

   logic [NM-1:0]   grant_q;
   logic            hold;
   logic            gv, mcyc, mstb, mwe;
   logic [AW-1:0]   madr;
   logic [SW-1:0]   msel;
   logic [DW-1:0]   mdat;
   logic [DECW-1:0] idx;
   logic            mapped;
   logic            ack_r, serr_r, rty_r, err_r;
   logic            resp, at_lim, fire;
   logic            err_q, err_d;
   logic [TW-1:0]   wdog_q, wdog_d;

   assign hold = |(grant_q & bus.m_cyc_i);

   wb_rr_arbiter #(.N(NM)) u_arb (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req_i  (bus.m_cyc_i),
      .hold_i (hold),
      .gnt_o  (grant_q)
   );

   always_comb begin
      mcyc = 1'b0;
      mstb = 1'b0;
      mwe  = 1'b0;
      madr = '0;
      msel = '0;
      mdat = '0;
      for (int i = 0; i < NM; i++) begin
         if (grant_q[i]) begin
            mcyc = bus.m_cyc_i[i];
            mstb = bus.m_stb_i[i];
            mwe  = bus.m_we_i[i];
            madr = bus.m_adr_i[i*AW +: AW];
            msel = bus.m_sel_i[i*SW +: SW];
            mdat = bus.m_dat_i[i*DW +: DW];
         end
      end
   end

   assign gv     = |grant_q;
   assign idx    = madr[AW-1 -: DECW];
   assign mapped = gv && (int'(idx) < NS);

   assign ack_r  = mstb & pick(16'(bus.s_ack_i), idx, mapped);
   assign serr_r = mstb & pick(16'(bus.s_err_i), idx, mapped);
   assign rty_r  = mstb & pick(16'(bus.s_rty_i), idx, mapped);
   assign resp   = ack_r | serr_r | rty_r | err_q;

   // Slave strobe is cut on the limit cycle without looking at the slave
   // response, so a combinational slave ack cannot loop back into stb.
   assign at_lim = gv && mstb && (wdog_q == TW'(TIMEOUT - 1));
   assign fire   = at_lim && !resp;
   assign err_r  = serr_r | (gv & err_q) | fire;

   always_comb begin
      bus.s_cyc_o = '0;
      bus.s_stb_o = '0;
      bus.m_dat_o = '0;
      for (int k = 0; k < NS; k++) begin
         if (mapped && idx == DECW'(k)) begin
            bus.s_cyc_o[k] = mcyc;
            bus.s_stb_o[k] = mstb && !at_lim;
            bus.m_dat_o    = bus.s_dat_i[k*DW +: DW];
         end
      end
   end

   always_comb begin
      bus.m_ack_o = '0;
      bus.m_err_o = '0;
      bus.m_rty_o = '0;
      for (int i = 0; i < NM; i++) begin
         bus.m_ack_o[i] = grant_q[i] & ack_r;
         bus.m_err_o[i] = grant_q[i] & err_r;
         bus.m_rty_o[i] = grant_q[i] & rty_r;
      end
   end

   assign bus.s_we_o  = mwe;
   assign bus.s_adr_o = madr;
   assign bus.s_sel_o = msel;
   assign bus.s_dat_o = mdat;

   always_comb begin
      err_d  = gv && mstb && !mapped && !err_q;
      wdog_d = wdog_q + 1'b1;
      if (!gv || !mstb || resp || fire) begin
         wdog_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q  <= 1'b0;
         wdog_q <= '0;
      end else begin
         err_q  <= err_d;
         wdog_q <= wdog_d;
      end
   end

   assign grant_o = grant_q;
   assign tmo_o   = fire;

endmodule

// File: tb/tb_wb_shared_ic.sv
// Directed bench for wb_shared_ic: master responses go through a
// scoreboard queue, grant and slave strobes are checked inline.
module tb_wb_shared_ic;

   localparam int NM  = 2;
   localparam int NS  = 4;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int TMO = 8;

   typedef struct packed {
      logic [1:0]  ack;
      logic [1:0]  err;
      logic [1:0]  rty;
      logic [31:0] dat;
      logic        tmo;
   } rsp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] grant;
   logic       tmo;
   rsp_t       exp_q[$];
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   wb_shared_ic_if #(.NM(NM), .NS(NS), .DW(DW), .AW(AW)) bus ();

   wb_shared_ic #(
      .NM(NM), .NS(NS), .DW(DW), .AW(AW), .TIMEOUT(TMO)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .bus     (bus),
      .grant_o (grant),
      .tmo_o   (tmo)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      rsp_t a;
      rsp_t e;
      if (!rst && (|bus.m_ack_o || |bus.m_err_o ||
                   |bus.m_rty_o || tmo)) begin
         a = {bus.m_ack_o, bus.m_err_o, bus.m_rty_o,
              bus.m_dat_o, tmo};
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got %h want none", a);
         end else begin
            e = exp_q.pop_front();
            chk("rsp", 64'(a), 64'(e));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   task automatic mset(input int m, input logic cyc, input logic stb,
                       input logic we, input logic [31:0] adr);
      bus.m_cyc_i[m]          = cyc;
      bus.m_stb_i[m]          = stb;
      bus.m_we_i[m]           = we;
      bus.m_adr_i[m*AW +: AW] = adr;
      bus.m_dat_i[m*DW +: DW] = 32'hCAFE_0000 + 32'(m);
      bus.m_sel_i[m*4 +: 4]   = 4'hF;
   endtask

   task automatic push(input logic [1:0] ack, input logic [1:0] err,
                       input logic [31:0] dat, input logic t);
      rsp_t r;
      r.ack = ack;
      r.err = err;
      r.rty = 2'b00;
      r.dat = dat;
      r.tmo = t;
      exp_q.push_back(r);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      bus.m_we_i  = '0;
      bus.m_adr_i = '0;
      bus.m_sel_i = '0;
      bus.m_dat_i = '0;
      bus.s_dat_i = '0;
      bus.s_ack_i = '0;
      bus.s_err_i = '0;
      bus.s_rty_i = '0;

      // reset state
      repeat (2) tick();
      smp();
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_scyc", 64'(bus.s_cyc_o), 64'(0));
      chk("rst_sstb", 64'(bus.s_stb_o), 64'(0));
      chk("rst_mack", 64'(bus.m_ack_o), 64'(0));
      tick();
      rst = 1'b0;

      // 1: m0 read from slave 2
      mset(0, 1, 1, 0, 32'h2000_0004);
      smp();
      chk("t1_pre_scyc", 64'(bus.s_cyc_o), 64'(0));
      tick();
      push(2'b01, 2'b00, 32'hDEAD_BEEF, 1'b0);
      bus.s_dat_i[2*DW +: DW] = 32'hDEAD_BEEF;
      bus.s_ack_i = 4'b0100;
      smp();
      chk("t1_scyc", 64'(bus.s_cyc_o), 64'(4'b0100));
      chk("t1_sstb", 64'(bus.s_stb_o), 64'(4'b0100));
      chk("t1_grant", 64'(grant), 64'(2'b01));
      chk("t1_sadr", 64'(bus.s_adr_o), 64'(32'h2000_0004));
      tick();
      bus.s_ack_i = '0;
      mset(0, 0, 0, 0, 32'h0);
      tick();

      // 2: round-robin after a fresh reset
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      mset(0, 1, 0, 0, 32'h0);
      mset(1, 1, 0, 0, 32'h0);
      tick();
      smp();
      chk("t2_first", 64'(grant), 64'(2'b01));
      tick();
      mset(0, 0, 0, 0, 32'h0);
      tick();
      smp();
      chk("t2_handoff", 64'(grant), 64'(2'b10));
      tick();
      mset(1, 0, 0, 0, 32'h0);
      tick();
      smp();
      chk("t2_idle", 64'(grant), 64'(2'b00));
      tick();
      mset(0, 1, 0, 0, 32'h0);
      mset(1, 1, 0, 0, 32'h0);
      tick();
      smp();
      chk("t2_rr", 64'(grant), 64'(2'b01));
      tick();
      mset(0, 0, 0, 0, 32'h0);
      mset(1, 0, 0, 0, 32'h0);
      tick();

      // 3: m1 write to unmapped slave 5
      mset(1, 1, 1, 1, 32'h5000_0000);
      tick();
      smp();
      chk("t3_grant", 64'(grant), 64'(2'b10));
      chk("t3_sstb", 64'(bus.s_stb_o), 64'(0));
      chk("t3_scyc", 64'(bus.s_cyc_o), 64'(0));
      push(2'b00, 2'b10, 32'h0, 1'b0);
      tick();
      smp();
      tick();
      mset(1, 0, 0, 0, 32'h0);
      tick();

      // 4: watchdog on a silent slave 0, twice in a row
      mset(0, 1, 1, 0, 32'h0000_0010);
      tick();
      push(2'b00, 2'b01, 32'h0, 1'b1);
      repeat (6) tick();
      smp();
      chk("t4_stb7", 64'(bus.s_stb_o), 64'(4'b0001));
      tick();
      smp();
      chk("t4_stb8", 64'(bus.s_stb_o), 64'(0));
      chk("t4_cyc8", 64'(bus.s_cyc_o), 64'(4'b0001));
      push(2'b00, 2'b01, 32'h0, 1'b1);
      repeat (8) tick();
      smp();
      chk("t4_stb16", 64'(bus.s_stb_o), 64'(0));
      tick();
      mset(0, 0, 0, 0, 32'h0);
      tick();

      // 5: slave 1 acks in the watchdog cycle
      mset(0, 1, 1, 0, 32'h1000_0000);
      tick();
      repeat (7) tick();
      push(2'b01, 2'b00, 32'h1234_5678, 1'b0);
      bus.s_dat_i[1*DW +: DW] = 32'h1234_5678;
      bus.s_ack_i = 4'b0010;
      smp();
      chk("t5_tmo", 64'(tmo), 64'(0));
      tick();
      bus.s_ack_i = '0;
      mset(0, 0, 0, 0, 32'h0);
      tick();

      // 6: reset during a transfer
      mset(1, 1, 1, 0, 32'h3000_0000);
      tick();
      smp();
      chk("t6_scyc", 64'(bus.s_cyc_o), 64'(4'b1000));
      tick();
      rst = 1'b1;
      tick();
      smp();
      chk("t6_grant0", 64'(grant), 64'(0));
      chk("t6_scyc0", 64'(bus.s_cyc_o), 64'(0));
      tick();
      rst = 1'b0;
      mset(0, 1, 0, 0, 32'h0);
      tick();
      smp();
      chk("t6_first", 64'(grant), 64'(2'b01));
      tick();
      mset(0, 0, 0, 0, 32'h0);
      mset(1, 0, 0, 0, 32'h0);

      repeat (3) tick();
      while (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL missing_rsp: got none want %h", exp_q[0]);
         void'(exp_q.pop_front());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
